seg7_scan: RTL and testbench
============================

# seg7_scan

Multiplexed scan driver for a multi-digit common-cathode 7-segment display. Accepts a packed hex word over a valid/ready load handshake, holds it tear-free, and walks the digits one at a time. Per digit it presents a 4-bit nibble plus decimal point to the downstream 7-segment decoder, and drives an active-low digit-select line, with a blanking gap between digits to suppress ghosting.

## Interface
- `DIGITS`, default 4: number of digits, legal range 2..8.
- `REFRESH_DIV`, default 12000: clk cycles each digit is lit (1 kHz per digit at 12 MHz); must be ≥2.
- `BLANK_CYCLES`, default 120: clk cycles all digits are off between digits; must be ≥1.
- `clk` in 1: single system clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `load_valid` in 1: load request.
- `load_ready` out 1: block can accept a load.
- `load_data` in 4*DIGITS: hex digits; digit 0 = bits [3:0].
- `load_dp` in DIGITS: decimal point per digit; bit i = digit i.
- `nib` out 4: current digit value, to the decoder input.
- `dp` out 1: current digit decimal point.
- `blank` out 1: high when no digit is lit. Downstream gates segments with it.
- `dig_n` out DIGITS: active-low one-hot digit select.

## Operation
- Storage:
  - Display register `disp_data`/`disp_dp`.
  - Pending register `pend_data`/`pend_dp` with flag `pend_v`.
- Load:
  - `load_ready = ~pend_v`.
  - A transfer occurs when `load_valid & load_ready` at a clk edge. It captures into pending and sets `pend_v`.
- Commit: on the BLANK→SHOW transition into digit 0 with `pend_v=1`:
  - Pending is copied to display.
  - `pend_v` is cleared.
  - This is the only point where display contents change, so there is no mid-frame tearing.
- State machine, 2 states. Counter `cnt` width `$clog2(max(REFRESH_DIV,BLANK_CYCLES))`; digit index `idx` width `$clog2(DIGITS)`.
  - SHOW:
    - `dig_n` has bit `idx` low.
    - `nib` = `disp_data[4*idx+:4]`, `dp` = `disp_dp[idx]`, `blank`=0.
    - After REFRESH_DIV cycles → BLANK, `cnt` reset.
  - BLANK:
    - `dig_n` all ones, `blank`=1, `nib`/`dp` hold their previous values.
    - After BLANK_CYCLES cycles → SHOW with `idx+1`, wrapping from DIGITS-1 to 0.
- Reset values:
  - State BLANK, `idx`=DIGITS-1, `cnt`=0.
  - Display and pending registers 0, `pend_v`=0.
  - Outputs: `dig_n` all ones, `nib`=0, `dp`=0, `blank`=1, `load_ready`=1.
  - As a result, the first SHOW after reset is digit 0, and it carries any commit.
- Boundaries:
  - A load accepted in the same cycle as a commit goes to pending only. It is displayed from the following frame.
  - A commit clears `pend_v`; `load_ready` rises the next cycle.
  - Reset asserted mid-operation forces all reset values immediately (asynchronous); a pending value is lost.
  - `load_valid` held with `load_ready` low is not an error. The requester holds data stable until `load_ready`.

## Timing
- All outputs registered except `load_ready`, which is a direct function of the `pend_v` flop.
- Digit period = REFRESH_DIV+BLANK_CYCLES cycles; frame = DIGITS × digit period.
- Load-to-display latency: from 1 cycle (load accepted in the cycle before a digit-0 commit) to one full frame plus 1 cycle.
- `dig_n`, `nib`, `dp` and `blank` change on the same edge; SHOW values are stable for exactly REFRESH_DIV cycles.

## Configuration
- Macro `SEG7_LEADING_ZERO_BLANK_EN`.
- Defined: a digit i>0 is suppressed when it and every higher digit have nibble 0 and dp 0. During its SHOW slot it keeps `dig_n` all ones and `blank`=1. Digit 0 is never suppressed. Slot timing is unchanged.
- Undefined: every digit is lit in its slot.

## Structure
- Shared package `seg7_pkg`: state encodings `ST_SHOW`/`ST_BLANK` and default parameter constants.
- Sub-module `seg7_slot_timer`:
  - Loadable down-counter with terminal-count pulse.
  - Used for both the SHOW and BLANK durations.
- FSM, registers and digit muxing live in `seg7_scan`.

## Test plan
All scenarios use DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=2.
- Reset:
  - `rst_n`=0 → `dig_n`=4'b1111, `blank`=1, `nib`=0, `load_ready`=1.
  - After release, 2 BLANK cycles, then digit 0 lit with `nib`=0.
- Scan order:
  - Load 16'h12A7 with dp 4'b0100, then wait for the commit.
  - `nib` sequence 7,A,2,1 with `dig_n` 1110,1101,1011,0111.
  - Each digit lit 4 cycles with 2 blank cycles between; `dp`=1 only on digit 2.
- Back-pressure:
  - Load 16'h1111, then present 16'h2222 immediately.
  - `load_ready`=0 until the digit-0 commit; 16'h1111 shows for that frame.
  - 16'h2222 is accepted the cycle after and shown from the next frame.
- Reset mid-frame:
  - Assert `rst_n` low during the digit-2 SHOW with `pend_v`=1.
  - Same cycle: `dig_n`=1111 and `pend_v`=0; display register reads 0 after release.
- Leading-zero blanking:
  - Load 16'h0030 with dp 0.
  - With macro: digits 3 and 2 slots dark, digit 1 shows 3, digit 0 shows 0.
  - Without macro: all four digits lit.
- All-zero:
  - Load 16'h0000 with dp 4'b0010 and the macro defined.
  - Digit 3 and 2 dark; digit 1 lit with `nib`=0, `dp`=1; digit 0 lit with `nib`=0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the seg7 scan driver: FSM state encoding and
// default parameter values.
package seg7_pkg;

   typedef enum logic {
      ST_SHOW  = 1'b0,
      ST_BLANK = 1'b1
   } seg7_state_e;

   localparam int unsigned DEF_DIGITS       = 4;
   localparam int unsigned DEF_REFRESH_DIV  = 12000;
   localparam int unsigned DEF_BLANK_CYCLES = 120;

endpackage

// File: rtl/seg7_slot_timer.sv
// Loadable down-counter with a terminal-count flag; times both the lit
// (SHOW) and dark (BLANK) slots of the scan driver.
module seg7_slot_timer #(
   parameter int unsigned            CNT_W   = 8,
   parameter logic [CNT_W-1:0]       RST_VAL = '0
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   output logic             o_tc
);

   logic [CNT_W-1:0] r_cnt;

   // Reload on request, otherwise count down and park at zero.
   // The reset value is the first slot's length minus one, so the slot that
   // follows reset is as long as any other slot of the same kind.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= RST_VAL;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/seg7_scan.sv
// Multiplexed scan driver for a common-cathode 7-segment display.
// Holds a tear-free display word, accepts new words over a valid/ready
// handshake into a pending register, and commits at the start of each frame.
// Optional feature macro: SEG7_LEADING_ZERO_BLANK_EN (suppress leading zeros).
module seg7_scan
   import seg7_pkg::*;
#(
   parameter int unsigned DIGITS       = DEF_DIGITS,
   parameter int unsigned REFRESH_DIV  = DEF_REFRESH_DIV,
   parameter int unsigned BLANK_CYCLES = DEF_BLANK_CYCLES
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load_valid,
   output logic                  load_ready,
   input  logic [4*DIGITS-1:0]   load_data,
   input  logic [DIGITS-1:0]     load_dp,
   output logic [3:0]            nib,
   output logic                  dp,
   output logic                  blank,
   output logic [DIGITS-1:0]     dig_n
);

   localparam int unsigned MAX_DUR = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
   localparam int unsigned CNT_W   = $clog2(MAX_DUR);
   localparam int unsigned IDX_W   = $clog2(DIGITS);

   localparam logic [CNT_W-1:0] LD_SHOW  = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] LD_BLANK = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

   seg7_state_e             r_state;
   seg7_state_e             w_state_nxt;
   logic [IDX_W-1:0]        r_idx;
   logic [IDX_W-1:0]        w_idx_nxt;

   logic [4*DIGITS-1:0]     r_disp_data;
   logic [DIGITS-1:0]       r_disp_dp;
   logic [4*DIGITS-1:0]     r_pend_data;
   logic [DIGITS-1:0]       r_pend_dp;
   logic                    r_pend_v;

   logic [3:0]              r_nib;
   logic                    r_dp;
   logic                    r_blank;
   logic [DIGITS-1:0]       r_dig_n;

   logic                    w_tc;
   logic                    w_tmr_load;
   logic [CNT_W-1:0]        w_tmr_val;
   logic                    w_accept;
   logic                    w_commit;
   logic [4*DIGITS-1:0]     w_disp_data_nxt;
   logic [DIGITS-1:0]       w_disp_dp_nxt;
   logic [3:0]              w_show_nib;
   logic                    w_show_dp;
   logic                    w_suppress;
   logic [3:0]              w_nib_nxt;
   logic                    w_dp_nxt;
   logic                    w_blank_nxt;
   logic [DIGITS-1:0]       w_dig_n_nxt;

   seg7_slot_timer #(
      .CNT_W   (CNT_W),
      .RST_VAL (LD_BLANK)
   ) u_slot_timer (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_load     (w_tmr_load),
      .i_load_val (w_tmr_val),
      .o_tc       (w_tc)
   );

   assign load_ready = ~r_pend_v;
   assign w_accept   = load_valid & ~r_pend_v;

   // Next state, next digit index and timer reload on slot expiry.
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_tmr_load  = 1'b0;
      w_tmr_val   = LD_SHOW;
      case (r_state)
         ST_SHOW: begin
            if (w_tc) begin
               w_state_nxt = ST_BLANK;
               w_tmr_load  = 1'b1;
               w_tmr_val   = LD_BLANK;
            end
         end
         ST_BLANK: begin
            if (w_tc) begin
               w_state_nxt = ST_SHOW;
               w_idx_nxt   = (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
               w_tmr_load  = 1'b1;
               w_tmr_val   = LD_SHOW;
            end
         end
         default: begin
            w_state_nxt = ST_BLANK;
         end
      endcase
   end

   // Commit only when entering digit 0, so a frame never mixes two words.
   assign w_commit        = (r_state == ST_BLANK) & w_tc & (w_idx_nxt == '0) & r_pend_v;
   assign w_disp_data_nxt = w_commit ? r_pend_data : r_disp_data;
   assign w_disp_dp_nxt   = w_commit ? r_pend_dp   : r_disp_dp;

   // Select the nibble and decimal point of the digit about to be shown,
   // using post-commit display contents.
   always_comb begin
      w_show_nib = '0;
      w_show_dp  = 1'b0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (w_idx_nxt == IDX_W'(i)) begin
            w_show_nib = w_disp_data_nxt[4*i +: 4];
            w_show_dp  = w_disp_dp_nxt[i];
         end
      end
   end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
   logic [DIGITS-1:0] w_lz_mask;
   logic              w_zero_run;

   // Mark digits above 0 whose own and all higher nibbles/dps are zero.
   always_comb begin
      w_lz_mask  = '0;
      w_zero_run = 1'b1;
      for (int unsigned k = 0; k < DIGITS - 1; k++) begin
         w_zero_run = w_zero_run
                    & (w_disp_data_nxt[4*(DIGITS-1-k) +: 4] == 4'h0)
                    & ~w_disp_dp_nxt[DIGITS-1-k];
         w_lz_mask[DIGITS-1-k] = w_zero_run;
      end
   end

   assign w_suppress = w_lz_mask[w_idx_nxt];
`else
   assign w_suppress = 1'b0;
`endif

   // Output values for the next cycle; they only change at slot boundaries.
   always_comb begin
      w_nib_nxt   = r_nib;
      w_dp_nxt    = r_dp;
      w_blank_nxt = r_blank;
      w_dig_n_nxt = r_dig_n;
      if (r_state == ST_SHOW && w_tc) begin
         w_blank_nxt = 1'b1;
         w_dig_n_nxt = '1;
      end else if (r_state == ST_BLANK && w_tc) begin
         w_nib_nxt = w_show_nib;
         w_dp_nxt  = w_show_dp;
         if (w_suppress) begin
            w_blank_nxt = 1'b1;
            w_dig_n_nxt = '1;
         end else begin
            w_blank_nxt = 1'b0;
            w_dig_n_nxt = ~(DIGITS'(1) << w_idx_nxt);
         end
      end
   end

   // FSM state and digit index register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_BLANK;
         r_idx   <= IDX_LAST;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   // Pending capture on handshake and display update on frame commit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_disp_data <= '0;
         r_disp_dp   <= '0;
         r_pend_data <= '0;
         r_pend_dp   <= '0;
         r_pend_v    <= 1'b0;
      end else begin
         if (w_commit) begin
            r_disp_data <= r_pend_data;
            r_disp_dp   <= r_pend_dp;
            r_pend_v    <= 1'b0;
         end
         if (w_accept) begin
            r_pend_data <= load_data;
            r_pend_dp   <= load_dp;
            r_pend_v    <= 1'b1;
         end
      end
   end

   // Registered display outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_nib   <= '0;
         r_dp    <= 1'b0;
         r_blank <= 1'b1;
         r_dig_n <= '1;
      end else begin
         r_nib   <= w_nib_nxt;
         r_dp    <= w_dp_nxt;
         r_blank <= w_blank_nxt;
         r_dig_n <= w_dig_n_nxt;
      end
   end

   assign nib   = r_nib;
   assign dp    = r_dp;
   assign blank = r_blank;
   assign dig_n = r_dig_n;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan with DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=2.
// Honours SEG7_LEADING_ZERO_BLANK_EN when the design is built with it.
module tb_seg7_scan;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
   localparam bit LZB = 1'b1;
`else
   localparam bit LZB = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load_valid;
   logic        load_ready;
   logic [15:0] load_data;
   logic [3:0]  load_dp;
   logic [3:0]  nib;
   logic        dp;
   logic        blank;
   logic [3:0]  dig_n;

   int unsigned n_vec  = 0;
   int unsigned n_miss = 0;

   seg7_scan #(
      .DIGITS       (4),
      .REFRESH_DIV  (4),
      .BLANK_CYCLES (2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_data  (load_data),
      .load_dp    (load_dp),
      .nib        (nib),
      .dp         (dp),
      .blank      (blank),
      .dig_n      (dig_n)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present one word; called while load_ready is high.
   task automatic load_word(input logic [15:0] d, input logic [3:0] p);
      load_valid = 1'b1;
      load_data  = d;
      load_dp    = p;
      @(negedge clk);
      chk("ld_ack", {31'b0, load_ready}, 32'd0);
      load_valid = 1'b0;
   endtask

   // Advance to the first cycle of the next digit-0 SHOW slot.
   task automatic sync_digit0();
      int n = 0;
      while (dig_n == 4'b1110 && n < 100) begin
         @(negedge clk);
         n++;
      end
      while (dig_n != 4'b1110 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("sync_d0", {28'b0, dig_n}, 32'he);
   endtask

   // Check one full frame starting at the first digit-0 SHOW cycle.
   task automatic check_frame(input string tag, input logic [15:0] en,
                              input logic [3:0] edp, input logic [3:0] lit);
      logic [3:0] exp_sel;
      for (int d = 0; d < 4; d++) begin
         exp_sel = ~(4'b0001 << d);
         for (int c = 0; c < 6; c++) begin
            if (c < 4 && lit[d]) begin
               chk($sformatf("%s_d%0d_c%0d_sel", tag, d, c), {28'b0, dig_n}, {28'b0, exp_sel});
               chk($sformatf("%s_d%0d_c%0d_blank", tag, d, c), {31'b0, blank}, 32'd0);
               chk($sformatf("%s_d%0d_c%0d_dp", tag, d, c), {31'b0, dp}, {31'b0, edp[d]});
            end else begin
               chk($sformatf("%s_d%0d_c%0d_sel", tag, d, c), {28'b0, dig_n}, 32'hf);
               chk($sformatf("%s_d%0d_c%0d_blank", tag, d, c), {31'b0, blank}, 32'd1);
            end
            if (lit[d])
               chk($sformatf("%s_d%0d_c%0d_nib", tag, d, c), {28'b0, nib}, {28'b0, en[4*d +: 4]});
            @(negedge clk);
         end
      end
   endtask

   // Release reset and check the two BLANK cycles before digit 0.
   task automatic release_reset();
      rst_n = 1'b1;
      @(negedge clk);
      chk("rel_blank", {31'b0, blank}, 32'd1);
      chk("rel_sel", {28'b0, dig_n}, 32'hf);
      @(negedge clk);
      chk("rel_d0_sel", {28'b0, dig_n}, 32'he);
      chk("rel_d0_nib", {28'b0, nib}, 32'd0);
      chk("rel_d0_blank", {31'b0, blank}, 32'd0);
   endtask

   initial begin
      int n;
      rst_n      = 1'b0;
      load_valid = 1'b0;
      load_data  = '0;
      load_dp    = '0;

      // Reset state
      @(negedge clk);
      chk("rst_sel", {28'b0, dig_n}, 32'hf);
      chk("rst_blank", {31'b0, blank}, 32'd1);
      chk("rst_nib", {28'b0, nib}, 32'd0);
      chk("rst_dp", {31'b0, dp}, 32'd0);
      chk("rst_ready", {31'b0, load_ready}, 32'd1);
      @(negedge clk);
      release_reset();
      check_frame("rstf", 16'h0000, 4'b0000, LZB ? 4'b0001 : 4'b1111);

      // Scan order
      load_word(16'h12A7, 4'b0100);
      sync_digit0();
      chk("scan_ready", {31'b0, load_ready}, 32'd1);
      check_frame("scan", 16'h12A7, 4'b0100, 4'b1111);

      // Back-pressure: second word held while the first is pending
      load_valid = 1'b1;
      load_data  = 16'h1111;
      load_dp    = 4'b0000;
      @(negedge clk);
      load_data  = 16'h2222;
      chk("bp_ready_lo", {31'b0, load_ready}, 32'd0);
      chk("bp_old_nib", {28'b0, nib}, 32'h7);
      sync_digit0();
      chk("bp_ready_rise", {31'b0, load_ready}, 32'd1);
      chk("bp_first_nib", {28'b0, nib}, 32'h1);
      @(negedge clk);
      chk("bp_accept2", {31'b0, load_ready}, 32'd0);
      chk("bp_hold_nib", {28'b0, nib}, 32'h1);
      load_valid = 1'b0;
      sync_digit0();
      check_frame("bp2", 16'h2222, 4'b0000, 4'b1111);

      // Reset mid-frame with a word pending
      load_word(16'h5678, 4'b0000);
      n = 0;
      while (dig_n != 4'b1011 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("mid_d2_sel", {28'b0, dig_n}, 32'hb);
      chk("mid_d2_nib", {28'b0, nib}, 32'h2);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_sel", {28'b0, dig_n}, 32'hf);
      chk("mid_rst_blank", {31'b0, blank}, 32'd1);
      chk("mid_rst_nib", {28'b0, nib}, 32'd0);
      chk("mid_rst_ready", {31'b0, load_ready}, 32'd1);
      @(negedge clk);
      @(negedge clk);
      release_reset();
      check_frame("midf1", 16'h0000, 4'b0000, LZB ? 4'b0001 : 4'b1111);
      check_frame("midf2", 16'h0000, 4'b0000, LZB ? 4'b0001 : 4'b1111);

      // Leading zeros
      load_word(16'h0030, 4'b0000);
      sync_digit0();
      check_frame("lz", 16'h0030, 4'b0000, LZB ? 4'b0011 : 4'b1111);

      // All-zero word with a decimal point on digit 1
      load_word(16'h0000, 4'b0010);
      sync_digit0();
      check_frame("zero", 16'h0000, 4'b0010, LZB ? 4'b0011 : 4'b1111);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
